// File: rtl/alu_pkg.sv
// Shared types, CRC polynomials and CRC helpers for the pipelined ALU core.
// The CRC helpers take a right-aligned message and its length in bits.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'b000,
    OP_OR       = 3'b001,
    OP_ERR_DATA = 3'b010,
    OP_ERR_CRC  = 3'b011,
    OP_ADD      = 3'b100,
    OP_SUB      = 3'b101,
    OP_ERR_OP   = 3'b110,
    OP_RST      = 3'b111
  } operation_t;

  localparam logic [3:0] CRC4_POLY = 4'b0011;  // x^4 + x + 1
  localparam logic [2:0] CRC3_POLY = 3'b011;   // x^3 + x + 1
  localparam int         CRC_MAX_W = 272;      // longest message the helpers accept

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  typedef struct packed {
    logic data;
    logic crc;
    logic op;
  } err_flags_t;

  function automatic logic [3:0] crc4_calc(input logic [CRC_MAX_W-1:0] data, input int len);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      if (i < len) begin
        fb  = crc[3] ^ data[i];
        crc = {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
      end
    end
    return crc;
  endfunction

  function automatic logic [2:0] crc3_calc(input logic [CRC_MAX_W-1:0] data, input int len);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      if (i < len) begin
        fb  = crc[2] ^ data[i];
        crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice carrying an opaque payload.
// Accepts new data whenever it is empty or its content is leaving this cycle.
module alu_pipe_stage #(
  parameter int P_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [P_W-1:0] i_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [P_W-1:0] o_data
);

  logic           r_valid;
  logic [P_W-1:0] r_data;

  assign o_ready = !rst && (!r_valid || i_ready);
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: the payload is reset as well because the outputs must read zero during reset;
  // state is always updated with <= so every slice samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!r_valid || i_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Pipelined ALU: parity/CRC4/opcode checks, AND/OR/ADD/SUB with flags, CRC3 on every
// response, and saturating ok/error counters on delivered responses.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_par,
  input  logic             in_b_par,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_crc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [2:0]       out_err_flags,
  output logic [2:0]       out_crc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int P1_W = WIDTH + 5;   // {err_flags, raw result, carry, overflow}
  localparam int P2_W = WIDTH + 11;  // {c, flags, err, err_flags, crc3}

  err_flags_t       w_err;
  logic [WIDTH-1:0] w_c_raw;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [P1_W-1:0]  w_p1;
  logic [P2_W-1:0]  w_out_data;
  logic             w_out_valid;
  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_err;

  assign w_add = {1'b0, in_b} + {1'b0, in_a};
  assign w_sub = {1'b0, in_b} - {1'b0, in_a};  // top bit is the borrow

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_err.data = (^in_a != in_a_par) || (^in_b != in_b_par);
    w_err.crc  = in_crc != crc4_calc(CRC_MAX_W'({in_b, in_a, 1'b1, in_op}), 2 * WIDTH + 4);
    w_err.op   = !(in_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB});
    w_c_raw    = '0;
    w_carry    = 1'b0;
    w_ovf      = 1'b0;
    case (operation_t'(in_op))
      OP_AND: w_c_raw = in_b & in_a;
      OP_OR:  w_c_raw = in_b | in_a;
      OP_ADD: begin
        {w_carry, w_c_raw} = w_add;
        w_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_add[WIDTH-1] != in_b[WIDTH-1]);
      end
      OP_SUB: begin
        {w_carry, w_c_raw} = w_sub;
        w_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_sub[WIDTH-1] != in_b[WIDTH-1]);
      end
      default: ;
    endcase
  end

  assign w_p1 = {w_err, w_c_raw, w_carry, w_ovf};

  // Turns checked raw results into the final response, blanking data on any error.
  function automatic logic [P2_W-1:0] stage2_logic(input logic [P1_W-1:0] p);
    err_flags_t       e;
    logic [WIDTH-1:0] c;
    alu_flags_t       f;
    logic             err;
    {e, c, f.carry, f.overflow} = p;
    f.zero     = 1'b0;
    f.negative = 1'b0;
    err        = |e;
    if (err) begin
      c = '0;
      f = '0;
    end else begin
      f.zero     = (c == '0);
      f.negative = c[WIDTH-1];
    end
    return {c, f, err, e, crc3_calc(CRC_MAX_W'({c, err, f}), WIDTH + 5)};
  endfunction

  if (PIPE_STAGES == 1) begin : g_one
    logic [P2_W-1:0] w_p2;
    assign w_p2 = stage2_logic(w_p1);
    alu_pipe_stage #(.P_W(P2_W)) u_stage (
      .clk(clk), .rst(rst),
      .i_valid(in_valid), .o_ready(in_ready), .i_data(w_p2),
      .o_valid(w_out_valid), .i_ready(out_ready), .o_data(w_out_data)
    );
  end else begin : g_two
    logic            w_v1;
    logic            w_rdy2;
    logic [P1_W-1:0] w_d1;
    logic [P2_W-1:0] w_p2;
    assign w_p2 = stage2_logic(w_d1);
    alu_pipe_stage #(.P_W(P1_W)) u_stage1 (
      .clk(clk), .rst(rst),
      .i_valid(in_valid), .o_ready(in_ready), .i_data(w_p1),
      .o_valid(w_v1), .i_ready(w_rdy2), .o_data(w_d1)
    );
    alu_pipe_stage #(.P_W(P2_W)) u_stage2 (
      .clk(clk), .rst(rst),
      .i_valid(w_v1), .o_ready(w_rdy2), .i_data(w_p2),
      .o_valid(w_out_valid), .i_ready(out_ready), .o_data(w_out_data)
    );
  end

  assign out_valid = w_out_valid;
  assign {out_c, out_flags, out_err, out_err_flags, out_crc} = w_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else if (cnt_clr) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else if (w_out_valid && out_ready) begin
      if (out_err) begin
        if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + CNT_W'(1);
      end else begin
        if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
      end
    end
  end

  assign cnt_ok  = r_cnt_ok;
  assign cnt_err = r_cnt_err;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed bench for alu_pipe_core: a two-stage instance (16-bit counters) and a
// one-stage instance (3-bit counters, so saturation is reachable) checked against a model.
module tb_alu_pipe_core;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ap;
    logic        bp;
    logic [3:0]  crc;
  } pkt_t;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  flags;
    logic        err;
    logic [2:0]  errf;
    logic [2:0]  crc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic        in_valid[2];
  logic        out_ready[2];
  logic        in_a_par[2];
  logic        in_b_par[2];
  logic [31:0] in_a[2];
  logic [31:0] in_b[2];
  logic [2:0]  in_op[2];
  logic [3:0]  in_crc[2];
  logic        in_ready[2];
  logic        out_valid[2];
  logic        out_err[2];
  logic [31:0] out_c[2];
  logic [3:0]  out_flags[2];
  logic [2:0]  out_err_flags[2];
  logic [2:0]  out_crc[2];
  logic [15:0] cnt_ok0, cnt_err0;
  logic [2:0]  cnt_ok1, cnt_err1;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] exp_ok[2];
  logic [15:0] exp_err[2];
  resp_t       last;

  always #5 clk = ~clk;

  alu_pipe_core #(.WIDTH(32), .PIPE_STAGES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_a_par(in_a_par[0]), .in_b_par(in_b_par[0]),
    .in_op(in_op[0]), .in_crc(in_crc[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_c(out_c[0]), .out_flags(out_flags[0]), .out_err(out_err[0]),
    .out_err_flags(out_err_flags[0]), .out_crc(out_crc[0]), .cnt_clr(cnt_clr),
    .cnt_ok(cnt_ok0), .cnt_err(cnt_err0)
  );

  alu_pipe_core #(.WIDTH(32), .PIPE_STAGES(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_a_par(in_a_par[1]), .in_b_par(in_b_par[1]),
    .in_op(in_op[1]), .in_crc(in_crc[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_c(out_c[1]), .out_flags(out_flags[1]), .out_err(out_err[1]),
    .out_err_flags(out_err_flags[1]), .out_crc(out_crc[1]), .cnt_clr(cnt_clr),
    .cnt_ok(cnt_ok1), .cnt_err(cnt_err1)
  );

  // ---------------- reference model (polynomial long division for the CRCs) --------------
  function automatic logic [3:0] ref_crc4(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] msg);
    logic [39:0] r;
    r = {msg, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic pkt_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    pkt_t p;
    p.a = a; p.b = b; p.op = op;
    p.ap = ^a; p.bp = ^b;
    p.crc = ref_crc4({b, a, 1'b1, op});
    return p;
  endfunction

  function automatic resp_t model(input pkt_t p);
    resp_t       r;
    longint      sa, sb, s;
    logic [32:0] wide;
    r  = '0;
    sa = longint'($signed(p.a));
    sb = longint'($signed(p.b));
    s  = 0;
    r.errf[2] = ((^p.a) !== p.ap) || ((^p.b) !== p.bp);
    r.errf[1] = (p.crc !== ref_crc4({p.b, p.a, 1'b1, p.op}));
    r.errf[0] = !(p.op inside {3'b000, 3'b001, 3'b100, 3'b101});
    r.err     = |r.errf;
    if (!r.err) begin
      case (p.op)
        3'b000: r.c = p.b & p.a;
        3'b001: r.c = p.b | p.a;
        3'b100: begin
          wide = {1'b0, p.b} + {1'b0, p.a};
          r.c = wide[31:0]; r.flags[3] = wide[32]; s = sb + sa;
        end
        3'b101: begin
          r.c = p.b - p.a; r.flags[3] = (p.b < p.a); s = sb - sa;
        end
        default: ;
      endcase
      r.flags[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r.flags[1] = (r.c == 32'd0);
      r.flags[0] = r.c[31];
    end
    r.crc = ref_crc3({r.c, r.err, r.flags});
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input pkt_t p);
    in_a[d] = p.a; in_b[d] = p.b; in_op[d] = p.op;
    in_a_par[d] = p.ap; in_b_par[d] = p.bp; in_crc[d] = p.crc;
  endtask

  function automatic resp_t get_out(input int d);
    return {out_c[d], out_flags[d], out_err[d], out_err_flags[d], out_crc[d]};
  endfunction

  function automatic logic [15:0] get_ok(input int d);
    return (d == 0) ? cnt_ok0 : {13'd0, cnt_ok1};
  endfunction

  function automatic logic [15:0] get_err(input int d);
    return (d == 0) ? cnt_err0 : {13'd0, cnt_err1};
  endfunction

  task automatic bump(input int d, input logic err);
    logic [15:0] mx = (d == 0) ? 16'hFFFF : 16'h0007;
    if (err) begin
      if (exp_err[d] != mx) exp_err[d] = exp_err[d] + 16'd1;
    end else begin
      if (exp_ok[d] != mx) exp_ok[d] = exp_ok[d] + 16'd1;
    end
  endtask

  // One packet through an idle pipe with out_ready high; checks latency, response, counters.
  task automatic run_one(input int d, input pkt_t p, input string name);
    resp_t exp_r = model(p);
    int    lat;
    drive(d, p);
    in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    #1;
    n_vec++;
    if (in_ready[d] !== 1'b1) begin
      n_miss++; $display("FAIL %s d%0d in_ready: got %b want 1", name, d, in_ready[d]);
    end
    tick();
    in_valid[d] = 1'b0;
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 8) begin tick(); lat++; end
    n_vec++;
    if (lat != ((d == 0) ? 2 : 1)) begin
      n_miss++; $display("FAIL %s d%0d latency: got %0d want %0d", name, d, lat, (d == 0) ? 2 : 1);
    end
    last = get_out(d);
    n_vec++;
    if (last !== exp_r) begin
      n_miss++; $display("FAIL %s d%0d resp: got %h want %h", name, d, last, exp_r);
    end
    bump(d, exp_r.err);
    tick();
    n_vec++;
    if (get_ok(d) !== exp_ok[d] || get_err(d) !== exp_err[d]) begin
      n_miss++;
      $display("FAIL %s d%0d counters: got ok=%0d err=%0d want ok=%0d err=%0d",
               name, d, get_ok(d), get_err(d), exp_ok[d], exp_err[d]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cnt_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      drive(d, '0);
      exp_ok[d] = '0; exp_err[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0 || get_out(d) !== '0 ||
          get_ok(d) !== 16'd0 || get_err(d) !== 16'd0) begin
        n_miss++;
        $display("FAIL reset d%0d: got v=%b rdy=%b out=%h ok=%0d err=%0d want all 0",
                 d, out_valid[d], in_ready[d], get_out(d), get_ok(d), get_err(d));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (in_ready[d] !== 1'b1) begin
        n_miss++; $display("FAIL post_reset d%0d in_ready: got %b want 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_add();
    run_one(0, mk(32'h0000_0001, 32'hFFFF_FFFF, 3'b100), "add_wrap");
    n_vec++;
    if (last.c !== 32'd0 || last.flags !== 4'b1010 || last.err !== 1'b0 || cnt_ok0 !== 16'd1) begin
      n_miss++;
      $display("FAIL add_wrap hand: got c=%h flags=%b err=%b ok=%0d want c=0 flags=1010 err=0 ok=1",
               last.c, last.flags, last.err, cnt_ok0);
    end
  endtask

  task automatic test_sub();
    run_one(0, mk(32'h0000_0001, 32'h8000_0000, 3'b101), "sub_ovf");
    n_vec++;
    if (last.c !== 32'h7FFF_FFFF || last.flags !== 4'b0100) begin
      n_miss++;
      $display("FAIL sub_ovf hand: got c=%h flags=%b want c=7fffffff flags=0100", last.c, last.flags);
    end
    run_one(0, mk(32'h0000_0005, 32'h0000_0003, 3'b101), "sub_borrow");
    n_vec++;
    if (last.c !== 32'hFFFF_FFFE || last.flags !== 4'b1001) begin
      n_miss++;
      $display("FAIL sub_borrow hand: got c=%h flags=%b want c=fffffffe flags=1001", last.c, last.flags);
    end
  endtask

  task automatic test_crc_err();
    pkt_t p = mk(32'h1234_5678, 32'h0000_0042, 3'b100);
    p.crc[0] = ~p.crc[0];
    run_one(0, p, "crc_err");
    n_vec++;
    if (last.err !== 1'b1 || last.errf !== 3'b010 || last.c !== 32'd0 || last.flags !== 4'd0 ||
        cnt_err0 !== 16'd1) begin
      n_miss++;
      $display("FAIL crc_err hand: got err=%b errf=%b c=%h flags=%b cnt_err=%0d want 1 010 0 0 1",
               last.err, last.errf, last.c, last.flags, cnt_err0);
    end
  endtask

  task automatic test_op_parity();
    pkt_t p = mk(32'h0F0F_0001, 32'h0000_0100, 3'b110);
    p.ap = ~p.ap;
    run_one(0, p, "op_par");
    n_vec++;
    if (last.errf !== 3'b101 || last.err !== 1'b1) begin
      n_miss++; $display("FAIL op_par hand: got errf=%b err=%b want 101 1", last.errf, last.err);
    end
    run_one(0, mk(32'h0, 32'h0, 3'b111), "op_rst_invalid");
    n_vec++;
    if (last.errf !== 3'b001) begin
      n_miss++; $display("FAIL op_rst_invalid hand: got errf=%b want 001", last.errf);
    end
  endtask

  task automatic test_and_or();
    run_one(0, mk(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b000), "and_zero");
    n_vec++;
    if (last.c !== 32'd0 || last.flags !== 4'b0010) begin
      n_miss++; $display("FAIL and_zero hand: got c=%h flags=%b want 0 0010", last.c, last.flags);
    end
    run_one(1, mk(32'h8000_0000, 32'h0000_00FF, 3'b001), "or_neg");
    n_vec++;
    if (last.c !== 32'h8000_00FF || last.flags !== 4'b0001) begin
      n_miss++; $display("FAIL or_neg hand: got c=%h flags=%b want 800000ff 0001", last.c, last.flags);
    end
    run_one(1, mk(32'h7FFF_FFFF, 32'h0000_0001, 3'b100), "add_ovf_p1");
  endtask

  // Eight packets streamed, out_ready dropped for five cycles while traffic is flowing.
  task automatic test_back_to_back(input int d);
    pkt_t    pk[8];
    resp_t   expq[$];
    resp_t   exp_r;
    resp_t   snap = '0;
    int      sent = 0;
    int      got = 0;
    int      cyc = 0;
    bit      stalled_prev = 1'b0;
    logic [2:0] ops[4] = '{3'b100, 3'b101, 3'b000, 3'b001};
    for (int i = 0; i < 8; i++)
      pk[i] = mk(32'h0123_4567 * (i + 1), 32'hF00D_0000 ^ (32'h1357_9BDF << i), ops[i % 4]);
    pk[5].bp = ~pk[5].bp;
    while (got < 8 && cyc < 60) begin
      in_valid[d] = (sent < 8);
      if (sent < 8) drive(d, pk[sent]);
      out_ready[d] = !(cyc >= 3 && cyc < 8);
      #1;
      if (out_valid[d] && out_ready[d]) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_miss++; $display("FAIL b2b d%0d spurious: got %h want nothing", d, get_out(d));
        end else begin
          exp_r = expq.pop_front();
          if (get_out(d) !== exp_r) begin
            n_miss++; $display("FAIL b2b d%0d pkt%0d: got %h want %h", d, got, get_out(d), exp_r);
          end
          bump(d, exp_r.err);
        end
        got++;
      end else if (out_valid[d]) begin
        if (stalled_prev) begin
          n_vec++;
          if (get_out(d) !== snap) begin
            n_miss++; $display("FAIL b2b d%0d hold: got %h want %h", d, get_out(d), snap);
          end
        end
        snap = get_out(d);
      end
      stalled_prev = out_valid[d] && !out_ready[d];
      if (in_valid[d] && in_ready[d]) begin
        expq.push_back(model(pk[sent]));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    n_vec++;
    if (got != 8 || expq.size() != 0) begin
      n_miss++; $display("FAIL b2b d%0d count: got %0d left %0d want 8 left 0", d, got, expq.size());
    end
    n_vec++;
    if (get_ok(d) !== exp_ok[d] || get_err(d) !== exp_err[d]) begin
      n_miss++;
      $display("FAIL b2b d%0d counters: got ok=%0d err=%0d want ok=%0d err=%0d",
               d, get_ok(d), get_err(d), exp_ok[d], exp_err[d]);
    end
    if (d == 1) begin
      n_vec++;
      if (cnt_ok1 !== 3'd7 || cnt_err1 !== 3'd1) begin
        n_miss++; $display("FAIL sat d1: got ok=%0d err=%0d want ok=7 err=1", cnt_ok1, cnt_err1);
      end
    end
  endtask

  task automatic test_cnt_clr();
    drive(0, mk(32'h0000_0010, 32'h0000_0020, 3'b100));
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    n_vec++;
    if (out_valid[0] !== 1'b1 || cnt_ok0 === 16'd0) begin
      n_miss++; $display("FAIL clr_pre: got v=%b ok=%0d want v=1 ok>0", out_valid[0], cnt_ok0);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin exp_ok[d] = '0; exp_err[d] = '0; end
    n_vec++;
    if (cnt_ok0 !== 16'd0 || cnt_err0 !== 16'd0 || cnt_ok1 !== 3'd0 || cnt_err1 !== 3'd0) begin
      n_miss++;
      $display("FAIL cnt_clr: got ok0=%0d err0=%0d ok1=%0d err1=%0d want all 0",
               cnt_ok0, cnt_err0, cnt_ok1, cnt_err1);
    end
    run_one(0, mk(32'h0000_0003, 32'h0000_0004, 3'b001), "after_clr");
  endtask

  task automatic test_reset_inflight();
    out_ready[0] = 1'b0;
    drive(0, mk(32'h1, 32'h2, 3'b100));
    in_valid[0] = 1'b1;
    tick();
    drive(0, mk(32'h3, 32'h4, 3'b101));
    tick();
    in_valid[0] = 1'b0;
    n_vec++;
    if (out_valid[0] !== 1'b1 || cnt_ok0 === 16'd0) begin
      n_miss++; $display("FAIL inflight_pre: got v=%b ok=%0d want v=1 ok>0", out_valid[0], cnt_ok0);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid[0] !== 1'b0 || out_c[0] !== 32'd0 || in_ready[0] !== 1'b0 ||
        cnt_ok0 !== 16'd0 || cnt_err0 !== 16'd0 || cnt_ok1 !== 3'd0) begin
      n_miss++;
      $display("FAIL inflight_rst: got v=%b c=%h rdy=%b ok0=%0d err0=%0d ok1=%0d want all 0",
               out_valid[0], out_c[0], in_ready[0], cnt_ok0, cnt_err0, cnt_ok1);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid[0] !== 1'b0 || cnt_ok0 !== 16'd0) begin
      n_miss++; $display("FAIL inflight_drop: got v=%b ok=%0d want v=0 ok=0", out_valid[0], cnt_ok0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_crc_err();
    test_op_parity();
    test_and_or();
    test_back_to_back(0);
    test_back_to_back(1);
    test_cnt_clr();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_pipe_core.md
Name: alu_pipe_core

Overview:
- Parametrised, pipelined successor of the team's mtm-style ALU.
- Accepts whole operand packets over a valid/ready interface.
- Checks operand parity and a CRC4 over each packet, decodes a 3-bit opcode, and computes result, flags and a CRC3.
- Returns error responses instead of results when checks fail, and keeps saturating ok/error counters.
- Sits between a packet deserialiser and serialiser, or is driven directly by the UVM/class-based bench.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- PIPE_STAGES, 2, register stages from input to output (1 or 2). Also the latency in cycles.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  packet present.
- in_ready  out  1  block accepts the packet this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_a_par  in  1  even parity of in_a.
- in_b_par  in  1  even parity of in_b.
- in_op  in  3  opcode (operation_t encoding).
- in_crc  in  4  CRC4 of the packet.
- out_valid  out  1  response present.
- out_ready  in  1  consumer accepts the response.
- out_c  out  WIDTH  result; 0 on error.
- out_flags  out  4  {carry, overflow, zero, negative}; 0 on error.
- out_err  out  1  error response.
- out_err_flags  out  3  {err_data, err_crc, err_op}.
- out_crc  out  3  CRC3 of the response.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_ok  out  CNT_W  good responses delivered.
- cnt_err  out  CNT_W  error responses delivered.

Behaviour:
- Reset (async, rst=1): every stage valid=0, all outputs 0, in_ready=0 while rst is high. In-flight packets are discarded; no counter update.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_ready = !stage1_valid || stage1_advances. Full throughput is one packet per cycle.
  - Response fields are held stable while out_valid && !out_ready.
- Latency: exactly PIPE_STAGES cycles from acceptance to out_valid, given no backpressure.
- Pipeline:
  - PIPE_STAGES=2: stage1 registers checks plus raw result; stage2 registers flags, CRC3 and counters.
  - PIPE_STAGES=1: everything is computed combinationally into one register.
- Checks:
  - err_data when either parity bit mismatches.
  - err_crc when in_crc != CRC4(poly x^4+x+1, init 0, MSB-first) over {in_b, in_a, 1'b1, in_op}.
  - err_op when in_op is not one of AND, OR, ADD, SUB. RST, ERR_* and other codes count as invalid.
- Error reporting: all detected bits are reported. If any bit is set: out_err=1, out_c=0, out_flags=0.
- Operations (WIDTH-bit, wrap-around):
  - AND: C = B&A.
  - OR: C = B|A.
  - ADD: C = B+A; carry = carry-out.
  - SUB: C = B-A; carry = borrow (B<A unsigned).
  - overflow = signed overflow for ADD/SUB; carry = overflow = 0 for AND/OR.
  - zero = (C==0); negative = C[WIDTH-1].
- out_crc: CRC3 (poly x^3+x+1, init 0, MSB-first) over {out_c, out_err, out_flags}. Applies to every response.
- Counters:
  - On each output transfer, increment cnt_err if out_err, else cnt_ok.
  - Saturate at all-ones.
  - cnt_clr wins over a simultaneous increment (counter = 0).

Decomposition:
- alu_pkg (shared package) holds:
  - operation_t;
  - CRC4_POLY and CRC3_POLY constants;
  - parametrised functions crc4_calc and crc3_calc;
  - alu_flags_t struct {carry, overflow, zero, negative};
  - err_flags_t struct {data, crc, op}.
- Sub-module alu_pipe_stage: one valid/ready register slice with a generic payload width. Instantiated PIPE_STAGES times.

Test Plan:
- W=32, ADD: A=0x0000_0001, B=0xFFFF_FFFF, parity and CRC correct -> after 2 cycles out_c=0, flags={1,0,1,0}, out_err=0, cnt_ok=1.
- SUB: A=1, B=0x8000_0000 -> out_c=0x7FFF_FFFF, flags={0,1,0,0}. out_crc matches the model.
- in_crc flipped bit0, op=ADD -> out_err=1, err_flags=3'b010, out_c=0, cnt_err=1.
- op=3'b110 with bad A parity and correct CRC -> err_flags=3'b101.
- Back-to-back 8 packets with out_ready held low for 5 cycles mid-stream -> no loss or duplication, in order, outputs stable while stalled. Repeat with PIPE_STAGES=1 (latency 1).
- rst asserted with 2 packets in flight -> out_valid=0 immediately, counters 0. cnt_clr coincident with an output transfer -> counter reads 0.
